// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side packer.
//   cnt_w     : width of a lane counter that must also hold the value PackCount
//   idle_w    : width of the idle counter, which saturates at TimeoutCycles-1
//   keep_mask : turns a word count into a thermometer keep mask (LSB = lane 0)
package fifo_pkg;

  localparam int MaxPack = 16;

  function automatic int cnt_w(input int pack);
    return $clog2(pack) + 1;
  endfunction

  function automatic int idle_w(input int tmo);
    return (tmo <= 2) ? 1 : $clog2(tmo);
  endfunction

  function automatic logic [MaxPack-1:0] keep_mask(input int n);
    logic [MaxPack-1:0] m;
    for (int i = 0; i < MaxPack; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/fifo_out_slot.sv
// Single-entry valid/ready output register. It captures a beat on load and
// holds data/keep/last while valid and downstream is not ready.
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture ld_* this cycle (only when free)
//   ld_data/keep/last : beat being loaded
//   ready             : downstream accept
//   valid/data/keep/last : registered beat
//   free              : slot can take a new beat this cycle
module fifo_out_slot #(
  parameter int W = 32,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic [K-1:0] ld_keep,
  input  logic         ld_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [K-1:0] keep,
  output logic         last,
  output logic         free
);

  assign free = ~valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
      keep  <= ld_keep;
      last  <= ld_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async FIFO. It pops DepthSize-bit words, packs
// PackCount of them into one beat (first word in lane 0) and offers the beat
// on valid/ready. A partial beat goes out on flush or after an idle timeout.
//   rclk, rrst        : read clock, synchronous active-high reset
//   rempty/rdata/rreq : FIFO read interface (rdata valid while rempty=0)
//   flush             : single-cycle pulse, forces out a partial beat
//   out_valid/ready   : output handshake
//   out_data/keep/last: packed beat, lane mask, beat-was-partial flag
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DepthSize     = 8,
  parameter int PackCount     = 4,
  parameter int TimeoutCycles = 16
) (
  input  logic                           rclk,
  input  logic                           rrst,
  input  logic                           rempty,
  input  logic [DepthSize-1:0]           rdata,
  output logic                           rreq,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DepthSize*PackCount-1:0] out_data,
  output logic [PackCount-1:0]           out_keep,
  output logic                           out_last
);

  localparam int CntW  = cnt_w(PackCount);
  localparam int IdleW = idle_w(TimeoutCycles);
  localparam logic [CntW-1:0]  PackFull = CntW'(PackCount);
  localparam logic [IdleW-1:0] IdleMax  =
    IdleW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  logic [PackCount-1:0][DepthSize-1:0] acc, acc_wp, ld_data;
  logic [CntW-1:0]      acc_count, ld_cnt;
  logic [IdleW-1:0]     idle_cnt;
  logic [PackCount-1:0] ld_keep;
  logic flush_pend, rst_dly, slot_free, has_data, full, timeout_hit;
  logic flush_cond, xfer, pop, merge, ld_last;

  always_comb begin
    has_data    = (acc_count != '0);
    full        = (acc_count == PackFull);
    timeout_hit = (TimeoutCycles != 0) && (idle_cnt == IdleMax);
    flush_cond  = flush | flush_pend | timeout_hit;
    xfer        = (full | (flush_cond & has_data)) & slot_free;
    // rst_dly keeps the FIFO untouched in the first cycle out of reset.
    rreq        = ~rempty & ~rrst & ~rst_dly & (~full | xfer);
    pop         = rreq & ~rempty;
    acc_wp      = acc;
    if (!full) acc_wp[acc_count[CntW-2:0]] = rdata;
    // A pop into a not-yet-full pack joins the beat a flush sends out in the
    // same cycle; a pop alongside a full-pack transfer starts the next pack.
    merge       = pop & ~full;
    ld_data     = merge ? acc_wp : acc;
    ld_cnt      = merge ? acc_count + 1'b1 : acc_count;
    ld_keep     = PackCount'(keep_mask(int'(ld_cnt)));
    ld_last     = (ld_cnt < PackFull);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc        <= '0;
      acc_count  <= '0;
      idle_cnt   <= '0;
      flush_pend <= 1'b0;
      rst_dly    <= 1'b1;
    end else begin
      rst_dly <= 1'b0;
      if (xfer) begin
        acc       <= '0;
        acc_count <= '0;
        if (pop && !merge) begin
          acc[0]    <= rdata;
          acc_count <= CntW'(1);
        end
      end else if (pop) begin
        acc       <= acc_wp;
        acc_count <= acc_count + 1'b1;
      end

      if (pop || xfer)
        idle_cnt <= '0;
      else if (has_data && (TimeoutCycles != 0) && (idle_cnt != IdleMax))
        idle_cnt <= idle_cnt + 1'b1;

      // A flush that cannot act now is remembered; with nothing accumulated
      // and nothing arriving it is dropped rather than held forever.
      if (xfer)
        flush_pend <= 1'b0;
      else if (flush && (!has_data || !slot_free))
        flush_pend <= 1'b1;
      else if (flush_pend && !has_data && !pop)
        flush_pend <= 1'b0;
    end
  end

  fifo_out_slot #(.W(DepthSize*PackCount), .K(PackCount)) u_slot (
    .clk     (rclk),
    .rst     (rrst),
    .load    (xfer),
    .ld_data (ld_data),
    .ld_keep (ld_keep),
    .ld_last (ld_last),
    .ready   (out_ready),
    .valid   (out_valid),
    .data    (out_data),
    .keep    (out_keep),
    .last    (out_last),
    .free    (slot_free)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

  logic        rclk = 1'b0, rrst = 1'b1, rempty = 1'b1, flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        rreq, out_valid, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] fq[$];
  int         pop_cyc[$];
  int         beat_cyc[$];
  int         nvec = 0, nerr = 0, npops = 0, cyc = 0;
  beat_t      held;
  logic       held_v = 1'b0;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DepthSize(8), .PackCount(4), .TimeoutCycles(16)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rreq      (rreq),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FIFO model: pop decided on the edge, head/empty updated 1 time unit later.
  always begin : fifo_model
    logic p;
    @(posedge rclk);
    cyc++;
    p = rreq && !rempty;
    #1;
    if (p) begin
      void'(fq.pop_front());
      npops++;
      pop_cyc.push_back(cyc);
    end
    rempty = (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge rclk) begin
    beat_t e;
    if (held_v && !rrst) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, held.d);
      chk("hold_keep", out_keep, held.k);
      chk("hold_last", out_last, held.l);
    end
    if (!rrst && out_valid && out_ready) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat: got %h/%h/%b expected none", out_data, out_keep, out_last);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_keep", out_keep, e.k);
        chk("beat_last", out_last, e.l);
      end
    end
    held_v = !rrst && out_valid && !out_ready;
    held   = '{out_data, out_keep, out_last};
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #2;
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back('{d, k, l});
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) tick();
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    // Reset state, with data already waiting in the FIFO.
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    tick(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_last", out_last, 0);
    chk("rst_rreq", rreq, 0);
    rrst = 1'b0;
    #1;
    chk("rreq_first_cycle", rreq, 0);

    // Full pack.
    expect_beat(32'h44332211, 4'b1111, 1'b0);
    drain(20);
    tick(2);
    chk("s1_pops", npops, 4);
    chk("s1_rreq_empty", rreq, 0);

    // Back-to-back packs.
    pop_cyc.delete(); beat_cyc.delete(); n0 = npops;
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
    expect_beat(32'h04030201, 4'b1111, 1'b0);
    expect_beat(32'h08070605, 4'b1111, 1'b0);
    drain(30);
    chk("s2_pops", npops - n0, 8);
    chk("s2_pop_span", (pop_cyc.size() == 8) ? pop_cyc[7] - pop_cyc[0] : -1, 7);
    chk("s2_beat_gap", (beat_cyc.size() == 2) ? beat_cyc[1] - beat_cyc[0] : -1, 4);

    // Backpressure.
    out_ready = 1'b0; n0 = npops;
    for (int i = 0; i < 12; i++) fq.push_back(8'(8'h21 + i));
    expect_beat(32'h24232221, 4'b1111, 1'b0);
    expect_beat(32'h28272625, 4'b1111, 1'b0);
    expect_beat(32'h2C2B2A29, 4'b1111, 1'b0);
    tick(10);
    chk("s3_rreq_full", rreq, 0);
    chk("s3_pops_stalled", npops - n0, 8);
    chk("s3_valid_held", out_valid, 1);
    chk("s3_data_held", out_data, 32'h24232221);
    out_ready = 1'b1;
    drain(30);
    chk("s3_pops_all", npops - n0, 12);

    // Explicit flush.
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    expect_beat(32'h0000BBAA, 4'b0011, 1'b1);
    tick(5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(10);

    // Idle timeout.
    n0 = npops;
    fq.push_back(8'h5C);
    expect_beat(32'h0000005C, 4'b0001, 1'b1);
    for (int i = 0; i < 10 && npops == n0; i++) tick();
    chk("s5_pop", npops - n0, 1);
    tick(15);
    chk("s5_no_beat_15", out_valid, 0);
    tick();
    chk("s5_beat_16", out_valid, 1);
    drain(5);

    // Reset mid-pack: the partial pack must be discarded.
    n0 = npops;
    fq.push_back(8'h71); fq.push_back(8'h72); fq.push_back(8'h73);
    tick(5);
    chk("s6_pops_acc", npops - n0, 3);
    fq.push_back(8'h99);
    rrst = 1'b1;
    tick();
    chk("s6_valid", out_valid, 0);
    chk("s6_data", out_data, 0);
    chk("s6_keep", out_keep, 0);
    chk("s6_last", out_last, 0);
    chk("s6_rreq_rst", rreq, 0);
    chk("s6_no_pop_rst", npops - n0, 3);
    rrst = 1'b0;
    #1;
    chk("s6_rreq_post", rreq, 0);
    expect_beat(32'h00000099, 4'b0001, 1'b1);
    drain(40);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
